// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use / redirect / fetch-wait hazard
// resolution, halt-and-drain sequencing, saturating stall and flush counters.
//
// state  | meaning
// RUN    | normal execution, hazards resolved per cycle
// DRAIN  | fetch stopped, retiring ID..WB for DRAIN_CYCLES advancing cycles
// HALTED | core stopped and empty, bubbles held in IF/ID and ID/EX
module pipe_hazard_ctrl #(
  parameter int CNT_W        = 16,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             ex_jump,
  input  logic             imem_ready,
  input  logic             halt_req,
  output logic             pc_write,
  output logic             pc_sel,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0]    D_LAST  = DW'(DRAIN_CYCLES - 1);
  localparam logic [DW-1:0]    D_ONE   = DW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] drain_left, drain_left_nxt;

  logic redir, lu, drain_adv, stall_inc, flush_inc;

  assign redir = ex_branch_taken | ex_jump;
  assign lu    = ex_memread & (ex_rt != 5'd0) &
                 ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

  // Drain progress is blocked only by a load-use bubble; redirects still advance.
  assign drain_adv = redir | ~lu;

  assign stall_inc = (state == ST_RUN) & ~redir & (lu | ~imem_ready);
  assign flush_inc = ((state == ST_RUN) | (state == ST_DRAIN)) & redir;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      drain_left <= D_LAST;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      drain_left <= drain_left_nxt;
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_ONE;
      if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

  always_comb begin
    state_nxt      = state;
    drain_left_nxt = drain_left;
    case (state)
      ST_RUN: begin
        drain_left_nxt = D_LAST;
        if (halt_req && !redir) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_adv) begin
          if (drain_left == '0) begin
            state_nxt      = ST_HALTED;
            drain_left_nxt = D_LAST;
          end else begin
            drain_left_nxt = drain_left - D_ONE;
          end
        end
      end
      ST_HALTED: begin
        drain_left_nxt = D_LAST;
        if (!halt_req) state_nxt = ST_RUN;
      end
      default: begin
        state_nxt      = ST_RUN;
        drain_left_nxt = D_LAST;
      end
    endcase
  end

  always_comb begin
    pc_write   = 1'b0;
    pc_sel     = 1'b0;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    halted     = 1'b0;
    if (rst) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else begin
      case (state)
        ST_RUN, ST_DRAIN: begin
          if (redir) begin
            pc_write   = 1'b1;
            pc_sel     = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (lu) begin
            ifid_write = 1'b0;
            idex_flush = 1'b1;
          end else if (state == ST_DRAIN || !imem_ready) begin
            ifid_flush = 1'b1;
          end else begin
            pc_write = 1'b1;
          end
        end
        ST_HALTED: begin
          halted     = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end
        default: begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with 4-bit counters so saturation is reachable.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       id_rs, id_rt, ex_rt;
  logic             id_uses_rt, ex_memread, ex_branch_taken, ex_jump;
  logic             imem_ready, halt_req;
  logic             pc_write, pc_sel, ifid_write, ifid_flush, idex_flush, halted;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // {pc_write, pc_sel, ifid_write, ifid_flush, idex_flush, halted}
  localparam logic [5:0] O_NORM  = 6'b101000;
  localparam logic [5:0] O_REDIR = 6'b111110;
  localparam logic [5:0] O_LU    = 6'b000010;
  localparam logic [5:0] O_WAIT  = 6'b001100;
  localparam logic [5:0] O_HALT  = 6'b001111;
  localparam logic [5:0] O_RST   = 6'b001110;

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .DRAIN_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt),
    .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump),
    .imem_ready(imem_ready), .halt_req(halt_req),
    .pc_write(pc_write), .pc_sel(pc_sel), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [5:0] exp);
    #1;
    chk(tag, {26'd0, pc_write, pc_sel, ifid_write, ifid_flush, idex_flush, halted},
        {26'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 1'b0;
    ex_memread = 1'b0; ex_rt = 5'd0;
    ex_branch_taken = 1'b0; ex_jump = 1'b0;
    imem_ready = 1'b1;
  endtask

  task automatic set_lu();
    ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
  endtask

  initial begin
    rst = 1'b1; halt_req = 1'b0; quiet();

    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      id_rs = 5'($urandom); id_rt = 5'($urandom); ex_rt = 5'($urandom);
      {id_uses_rt, ex_memread, ex_branch_taken, ex_jump, imem_ready, halt_req} = 6'($urandom);
      chk_out("reset_outputs", O_RST);
      tick();
    end
    rst = 1'b0; halt_req = 1'b0; quiet();
    chk_out("post_reset_run", O_NORM);
    chk("post_reset_stall", 32'(stall_cnt), 32'd0);
    chk("post_reset_flush", 32'(flush_cnt), 32'd0);
    tick();

    // Load-use on rs
    set_lu();
    chk_out("lu_rs_stall", O_LU);
    tick(); quiet();
    chk_out("lu_rs_resume", O_NORM);
    chk("lu_rs_cnt", 32'(stall_cnt), 32'd1);
    tick();

    // Load to r0 never stalls
    ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    chk_out("lu_r0_nostall", O_NORM);
    tick(); quiet();

    // rt match without id_uses_rt
    ex_memread = 1'b1; ex_rt = 5'd5; id_rt = 5'd5; id_uses_rt = 1'b0; id_rs = 5'd3;
    chk_out("lu_rt_unused", O_NORM);
    tick();
    chk("lu_nostall_cnt", 32'(stall_cnt), 32'd1);
    // rt match with id_uses_rt
    id_uses_rt = 1'b1;
    chk_out("lu_rt_used", O_LU);
    tick(); quiet();
    chk("lu_rt_cnt", 32'(stall_cnt), 32'd2);

    // Redirect beats load-use and fetch wait
    set_lu(); ex_branch_taken = 1'b1; imem_ready = 1'b0;
    chk_out("prio_redir", O_REDIR);
    tick(); quiet();
    chk("prio_flush_cnt", 32'(flush_cnt), 32'd1);
    chk("prio_stall_cnt", 32'(stall_cnt), 32'd2);
    ex_jump = 1'b1;
    chk_out("jump_redir", O_REDIR);
    tick(); quiet();
    chk("jump_flush_cnt", 32'(flush_cnt), 32'd2);

    // Fetch wait states
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_out("fetch_wait", O_WAIT);
      tick();
    end
    imem_ready = 1'b1;
    chk_out("fetch_resume", O_NORM);
    chk("fetch_stall_cnt", 32'(stall_cnt), 32'd5);
    tick();

    // Halt with one load-use cycle in DRAIN: halted after 6 cycles
    halt_req = 1'b1;
    chk_out("halt_accept", O_NORM);
    tick();
    halt_req = 1'b0; imem_ready = 1'b0;
    chk_out("drain_c1", O_WAIT);
    tick(); imem_ready = 1'b1;
    set_lu();
    chk_out("drain_lu", O_LU);
    tick(); quiet();
    chk("drain_lu_stall_cnt", 32'(stall_cnt), 32'd5);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) halt_req = 1'b1;
      chk_out("drain_tail", O_WAIT);
      tick();
    end
    ex_branch_taken = 1'b1;
    chk_out("halted_c6", O_HALT);
    tick();
    chk_out("halted_hold", O_HALT);
    chk("halted_redir_ignored", 32'(flush_cnt), 32'd2);
    tick(); quiet();
    halt_req = 1'b0;
    chk_out("halted_release", O_HALT);
    tick();
    chk_out("run_after_halt", O_NORM);
    tick();

    // Branch mid-DRAIN: drain length unchanged
    halt_req = 1'b1;
    chk_out("halt2_accept", O_NORM);
    tick(); halt_req = 1'b0;
    chk_out("drain2_c1", O_WAIT);
    tick();
    ex_branch_taken = 1'b1;
    chk_out("drain2_branch", O_REDIR);
    tick(); quiet();
    chk("drain2_flush_cnt", 32'(flush_cnt), 32'd3);
    chk_out("drain2_c3", O_WAIT);
    tick();
    chk_out("drain2_c4", O_WAIT);
    tick();
    chk_out("halted2_c5", O_HALT);
    tick();
    chk_out("run2_after_halt", O_NORM);

    // Halt request coinciding with redirect is deferred
    halt_req = 1'b1; ex_jump = 1'b1;
    chk_out("halt_redir_same", O_REDIR);
    tick(); quiet();
    chk_out("halt_deferred_accept", O_NORM);
    tick(); halt_req = 1'b0;
    chk_out("halt_deferred_drain", O_WAIT);
    tick();

    // Reset mid-DRAIN
    rst = 1'b1;
    chk_out("rst_mid_drain", O_RST);
    tick(); rst = 1'b0;
    chk_out("rst_mid_drain_run", O_NORM);
    chk("rst_clr_stall", 32'(stall_cnt), 32'd0);
    chk("rst_clr_flush", 32'(flush_cnt), 32'd0);

    // Saturation at 4'hF
    set_lu();
    for (int i = 0; i < 20; i++) tick();
    chk("sat_stall_20", 32'(stall_cnt), 32'd15);
    tick();
    chk("sat_stall_hold", 32'(stall_cnt), 32'd15);
    quiet();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
